// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode field values, ALUop encodings, fetch FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // ALUop encodings driven by the main control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Fetch FSM: waiting on imem, or holding an instruction for the core
  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: jump/jal target, taken-beq target, or sequential pc+4.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is consumed.
// Ports: pc_plus4/instr of the instruction being committed, control redirects
//        (branch, zero, jump, jal) -> next_pc.
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] instr,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jal,
  output logic [31:0] next_pc
);

  logic [31:0] br_offset;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        unused_opcode;

  // Word offset, sign-extended and scaled to bytes; carry out of bit 31 is dropped
  assign br_offset     = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign branch_target = pc_plus4 + br_offset;
  // Pseudo-direct target keeps the top nibble of the delay-slot address
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // The opcode field is decoded elsewhere; it plays no part in target math
  assign unused_opcode = ^instr[31:26];

  // j/jal outrank beq; j and jal share the same target
  always_comb begin
    next_pc = pc_plus4;
    if (jump || jal) begin
      next_pc = jump_target;
    end else if (branch && zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ack fetch, instruction hand-off.
// Latency: >=1 cycle in FETCH (until imem_ack) + >=1 cycle in ISSUE; 2 cycles/instr best case.
// Backpressure: instr_ready low holds ISSUE (instr/pc stable, no request) indefinitely.
// Ports: clk/reset; imem_req/imem_addr/imem_ack/imem_rdata to instruction memory;
//        instr/opcode/pc/pc_plus4/instr_valid/instr_ready to the core;
//        branch/zero/jump/jal redirects from control/ALU; fetch_err sticky timeout flag.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  input  logic        jal,
  output logic        fetch_err
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  tmo_cnt_q;
  logic [31:0]  tmo_cnt_d;
  logic         fetch_err_q;
  logic         imem_req_q;
  logic         instr_valid_q;
  logic [31:0]  next_pc_d;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_calc u_next_pc_calc (
    .pc_plus4 (pc_plus4),
    .instr    (instr_q),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .jal      (jal),
    .next_pc  (next_pc_d)
  );

  // Saturates at the limit so a long stall cannot wrap the counter
  assign tmo_cnt_d = (tmo_cnt_q == IMEM_TIMEOUT) ? tmo_cnt_q : tmo_cnt_q + 32'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      tmo_cnt_q     <= '0;
      fetch_err_q   <= 1'b0;
      imem_req_q    <= 1'b1;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            instr_q       <= imem_rdata;
            state_q       <= ISSUE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end else if (IMEM_TIMEOUT != 0) begin
            // Keep requesting; only flag the stall
            tmo_cnt_q <= tmo_cnt_d;
            if (tmo_cnt_d == IMEM_TIMEOUT) begin
              fetch_err_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          // Redirects are only meaningful in the commit cycle
          if (instr_ready) begin
            pc_q          <= next_pc_d;
            tmo_cnt_q     <= '0;
            state_q       <= FETCH;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= FETCH;
          imem_req_q    <= 1'b1;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a transaction-level PC model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jal;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  // Observations recorded by run_instr for the calling test to judge
  logic [31:0] obs_addr, obs_pc, obs_instr, obs_pc4, obs_next;
  logic [5:0]  obs_op;
  logic        obs_valid, obs_fetch_ok, obs_issue_ok, obs_next_req, obs_next_valid;
  int          obs_cycles, obs_req_cycles;

  fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .IMEM_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .opcode      (opcode),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jal         (jal),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference next-PC from the ISA rules, expressed arithmetically
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                           input logic br, input logic zr,
                                           input logic jp, input logic jl);
    int off;
    logic [31:0] seq;
    seq = cur_pc + 32'd4;
    if (jp || jl) return (seq & 32'hF000_0000) | ({6'd0, word[25:0]} << 2);
    if (br && zr) begin
      off = $signed(word[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic clear_inputs();
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0;
  endtask

  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one full fetch/issue/commit transaction starting at a FETCH negedge.
  task automatic run_instr(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                           input logic br, input logic zr, input logic jp, input logic jl);
    obs_addr = imem_addr; obs_fetch_ok = 1'b1; obs_req_cycles = 0; obs_cycles = 0;
    for (int i = 0; i <= ack_dly; i++) begin
      if (imem_req === 1'b1) obs_req_cycles++;
      if (imem_addr !== obs_addr || instr_valid !== 1'b0) obs_fetch_ok = 1'b0;
      imem_ack    = (i == ack_dly);
      imem_rdata  = (i == ack_dly) ? word : $urandom;
      // readiness and redirects while nothing is valid must be ignored
      instr_ready = 1'($urandom_range(0, 1));
      jump        = 1'($urandom_range(0, 1));
      branch      = 1'b1; zero = 1'b1;
      @(negedge clk); obs_cycles++;
    end
    clear_inputs();
    obs_valid = instr_valid; obs_pc = pc; obs_instr = instr; obs_op = opcode; obs_pc4 = pc_plus4;
    obs_issue_ok = 1'b1;
    for (int i = 0; i < rdy_dly; i++) begin
      imem_ack = 1'b1; imem_rdata = ~word;
      branch = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1)); jal = 1'($urandom_range(0, 1));
      @(negedge clk); obs_cycles++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || pc !== obs_pc || instr !== obs_instr)
        obs_issue_ok = 1'b0;
    end
    clear_inputs();
    instr_ready = 1'b1; branch = br; zero = zr; jump = jp; jal = jl;
    @(negedge clk); obs_cycles++;
    clear_inputs();
    obs_next = imem_addr; obs_next_req = imem_req; obs_next_valid = instr_valid;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; clear_inputs();
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL reset_req: got %b exp 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h exp 00000000", imem_addr); end
    n_checks++; if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h exp 00000000", instr); end
    n_checks++; if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b exp 0", fetch_err); end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin n_errors++; $display("FAIL reset_ack_ignored: valid %b req %b exp 0 1", instr_valid, imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    for (int k = 0; k < 3; k++) begin
      words[k] = $urandom;
      run_instr(words[k], 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++; if (obs_addr !== 32'(k * 4)) begin n_errors++; $display("FAIL seq_addr%0d: got %h exp %h", k, obs_addr, 32'(k * 4)); end
      n_checks++; if (obs_op !== words[k][31:26] || obs_instr !== words[k]) begin n_errors++; $display("FAIL seq_instr%0d: got %h/%h exp %h", k, obs_instr, obs_op, words[k]); end
      n_checks++; if (obs_cycles != 2 || obs_valid !== 1'b1 || !obs_fetch_ok) begin n_errors++; $display("FAIL seq_timing%0d: cycles %0d valid %b fetch_ok %b exp 2 1 1", k, obs_cycles, obs_valid, obs_fetch_ok); end
    end
    n_checks++; if (obs_next !== 32'h0000_000C) begin n_errors++; $display("FAIL seq_next: got %h exp 0000000c", obs_next); end
  endtask

  task automatic test_beq();
    run_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);        // 0x0C -> 0x10
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (obs_pc !== 32'h10) begin n_errors++; $display("FAIL beq_pc: got %h exp 00000010", obs_pc); end
    n_checks++; if (obs_next !== 32'h0C) begin n_errors++; $display("FAIL beq_taken: got %h exp 0000000c", obs_next); end
    run_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);        // 0x0C -> 0x10
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if (obs_next !== 32'h14) begin n_errors++; $display("FAIL beq_not_taken: got %h exp 00000014", obs_next); end
  endtask

  task automatic test_jump_jal();
    run_instr(32'h0BFF_FFFF, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0x0FFFFFFC
    n_checks++; if (obs_next !== 32'h0FFF_FFFC) begin n_errors++; $display("FAIL j_far: got %h exp 0ffffffc", obs_next); end
    run_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);          // -> 0x10000000
    run_instr(32'h0C00_0040, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks++; if (obs_pc4 !== 32'h1000_0004) begin n_errors++; $display("FAIL jal_link: got %h exp 10000004", obs_pc4); end
    n_checks++; if (obs_next !== 32'h1000_0100) begin n_errors++; $display("FAIL jal_over_beq: got %h exp 10000100", obs_next); end
    run_instr(32'h0800_0080, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    n_checks++; if (obs_next !== 32'h1000_0200) begin n_errors++; $display("FAIL j_over_beq: got %h exp 10000200", obs_next); end
    run_instr(32'h0C00_0010, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++; if (obs_next !== 32'h1000_0040) begin n_errors++; $display("FAIL j_and_jal: got %h exp 10000040", obs_next); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w;
    w = $urandom;
    run_instr(w, 5, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (obs_req_cycles != 6 || !obs_fetch_ok) begin n_errors++; $display("FAIL bp_req_held: cycles %0d stable %b exp 6 1", obs_req_cycles, obs_fetch_ok); end
    n_checks++; if (!obs_issue_ok) begin n_errors++; $display("FAIL bp_issue_stable: got %b exp 1", obs_issue_ok); end
    n_checks++; if (obs_instr !== w) begin n_errors++; $display("FAIL bp_instr: got %h exp %h", obs_instr, w); end
    n_checks++; if (obs_cycles != 10) begin n_errors++; $display("FAIL bp_cycles: got %0d exp 10", obs_cycles); end
    n_checks++; if (obs_next !== 32'h1000_0044 || obs_next_req !== 1'b1 || obs_next_valid !== 1'b0) begin n_errors++; $display("FAIL bp_next: got %h req %b valid %b exp 10000044 1 0", obs_next, obs_next_req, obs_next_valid); end
  endtask

  task automatic test_wrap();
    pulse_reset();
    run_instr(32'h1000_FFFE, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (obs_next !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_neg_offset: got %h exp fffffffc", obs_next); end
    run_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (obs_pc4 !== 32'h0) begin n_errors++; $display("FAIL wrap_pc4: got %h exp 00000000", obs_pc4); end
    n_checks++; if (obs_next !== 32'h0) begin n_errors++; $display("FAIL wrap_seq: got %h exp 00000000", obs_next); end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= 16; i++) begin
      clear_inputs();
      @(negedge clk);
      if (i == 15) begin
        n_checks++; if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL tmo_early: got %b exp 0", fetch_err); end
      end
      if (i == 16) begin
        n_checks++; if (fetch_err !== 1'b1) begin n_errors++; $display("FAIL tmo_set: got %b exp 1", fetch_err); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_errors++; $display("FAIL tmo_req_held: req %b addr %h exp 1 00000000", imem_req, imem_addr); end
      end
    end
    run_instr(32'h0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (fetch_err !== 1'b1) begin n_errors++; $display("FAIL tmo_sticky: got %b exp 1", fetch_err); end
    pulse_reset();
    n_checks++; if (fetch_err !== 1'b0) begin n_errors++; $display("FAIL tmo_cleared: got %b exp 0", fetch_err); end
  endtask

  task automatic test_reset_mid_fetch();
    run_instr(32'h0800_0010, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);  // -> 0x40
    n_checks++; if (obs_next !== 32'h40) begin n_errors++; $display("FAIL mid_setup: got %h exp 00000040", obs_next); end
    for (int i = 0; i < 17; i++) @(negedge clk);
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    reset = 1'b0; clear_inputs();
    n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_errors++; $display("FAIL mid_addr: got %h req %b exp 00000000 1", imem_addr, imem_req); end
    n_checks++; if (instr_valid !== 1'b0 || fetch_err !== 1'b0) begin n_errors++; $display("FAIL mid_state: valid %b err %b exp 0 0", instr_valid, fetch_err); end
    @(negedge clk);
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL mid_late_ack: got %b exp 0", instr_valid); end
  endtask

  task automatic test_random();
    logic [31:0] mpc, w, exp_next;
    logic br, zr, jp, jl;
    pulse_reset();
    mpc = 32'h0;
    for (int k = 0; k < 40; k++) begin
      w  = $urandom;
      br = 1'($urandom_range(0, 1)); zr = 1'($urandom_range(0, 1));
      jp = ($urandom_range(0, 5) == 0); jl = ($urandom_range(0, 5) == 0);
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 2), br, zr, jp, jl);
      exp_next = ref_next(mpc, w, br, zr, jp, jl);
      n_checks++; if (obs_addr !== mpc || obs_pc !== mpc) begin n_errors++; $display("FAIL rnd_pc%0d: addr %h pc %h exp %h", k, obs_addr, obs_pc, mpc); end
      n_checks++; if (obs_instr !== w || obs_op !== w[31:26] || obs_pc4 !== mpc + 32'd4) begin n_errors++; $display("FAIL rnd_issue%0d: instr %h op %h pc4 %h exp %h", k, obs_instr, obs_op, obs_pc4, w); end
      n_checks++; if (obs_next !== exp_next || !obs_issue_ok) begin n_errors++; $display("FAIL rnd_next%0d: got %h exp %h stable %b", k, obs_next, exp_next, obs_issue_ok); end
      mpc = exp_next;
    end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_beq();
    test_jump_jal();
    test_backpressure();
    test_wrap();
    test_timeout();
    test_reset_mid_fetch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
